cen_gen_multi: RTL and testbench

Multi-channel fractional clock-enable generator for the arcade core clock tree. It runs entirely in the master PLL clock domain and produces NUM_CH single-cycle clock-enable strobes. Each strobe has a runtime-programmable rational rate refclk·NUM/DEN. All channels are phase-aligned at a common origin, and a `locked` flag with a settle period gates them. This block replaces the fixed derived-clock outputs for CPU, video and audio sections.

---
 rtl/cen_gen_multi.sv | 72 +++++++
 tb/tb_cen_gen_multi.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cen_gen_multi.sv
// cen_gen_multi: phase-aligned fractional clock enables cen = refclk*num/den per channel, programmed via cfg_*, gated by locked/align
module cen_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 16,
  parameter int LOCK_CYC = 16,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM = {NUM_CH{ACC_W'(1)}},
  parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN = {NUM_CH{ACC_W'(4)}}
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
  output logic [NUM_CH-1:0] cen,
  output logic              align,
  output logic              locked
);
  localparam int CW = LOCK_CYC > 1 ? $clog2(LOCK_CYC) : 1;
  typedef enum logic [1:0] {ALIGN, SETTLE, LOCKED} state_t;
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic was_locked;
  logic wr;
  assign wr = cfg_we && (32'(cfg_ch) < NUM_CH);
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ALIGN;
      cnt <= '0;
      was_locked <= 1'b0;
    end else begin
      state <= next_state;
      cnt <= state == ALIGN ? CW'(LOCK_CYC - 1) : (state == SETTLE && cnt != '0) ? cnt - 1'b1 : cnt;
      was_locked <= state == LOCKED;
    end
  end
  always_comb begin
    next_state = wr ? ALIGN :
                 state == ALIGN ? SETTLE :
                 state == SETTLE ? (cnt == '0 ? LOCKED : SETTLE) : LOCKED;
  end
  always_comb begin
    locked = state == LOCKED;
    align = locked && !was_locked;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] num, den;
    logic [ACC_W:0] acc, s;
    logic valid, run, hit, cen_q;
    // num <= den keeps s < 2*den, so one subtraction restores acc < den
    assign s = acc + {1'b0, num};
    assign valid = den != '0 && num != '0 && num <= den;
    assign run = valid && next_state == LOCKED;
    assign hit = run && s >= {1'b0, den};
    assign cen[i] = cen_q;
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        num <= DEF_NUM[i*ACC_W +: ACC_W];
        den <= DEF_DEN[i*ACC_W +: ACC_W];
        acc <= '0;
        cen_q <= 1'b0;
      end else begin
        if (wr && cfg_ch == 3'(i)) begin
          num <= cfg_num;
          den <= cfg_den;
        end
        acc <= hit ? s - {1'b0, den} : run ? s : '0;
        cen_q <= hit;
      end
    end
  end
endmodule

// File: tb/tb_cen_gen_multi.sv
// tb_cen_gen_multi: randomized and directed check of cen_gen_multi against a floor(n*num/den) reference
module tb_cen_gen_multi;
  localparam int NUM_CH = 4;
  localparam int LOCK_CYC = 16;
  logic refclk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [15:0] cfg_num = '0, cfg_den = '0;
  logic [NUM_CH-1:0] cen;
  logic align, locked;
  int n_checks = 0, n_fail = 0;
  longint ecount, lock_edge;
  longint mnum[NUM_CH], mden[NUM_CH];
  cen_gen_multi #(.NUM_CH(NUM_CH), .ACC_W(16), .LOCK_CYC(LOCK_CYC)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_num(cfg_num), .cfg_den(cfg_den), .cen(cen), .align(align), .locked(locked)
  );
  always #5 refclk = ~refclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    ecount = 0;
    lock_edge = 1 + LOCK_CYC;
    for (int i = 0; i < NUM_CH; i++) begin
      mnum[i] = 1;
      mden[i] = 4;
    end
  endtask
  function automatic logic exp_locked();
    return rst_n && ecount >= lock_edge;
  endfunction
  function automatic logic [NUM_CH-1:0] exp_cen();
    logic [NUM_CH-1:0] r = '0;
    longint n = ecount - lock_edge + 1;
    for (int i = 0; i < NUM_CH; i++)
      if (exp_locked() && mden[i] != 0 && mnum[i] != 0 && mnum[i] <= mden[i])
        r[i] = (n * mnum[i]) / mden[i] > ((n - 1) * mnum[i]) / mden[i];
    return r;
  endfunction
  task automatic step();
    @(posedge refclk);
    if (!rst_n) model_reset();
    else begin
      ecount++;
      if (cfg_we && cfg_ch < NUM_CH) begin
        mnum[cfg_ch] = cfg_num;
        mden[cfg_ch] = cfg_den;
        lock_edge = ecount + 1 + LOCK_CYC;
      end
    end
    @(negedge refclk);
    check("locked", locked, exp_locked());
    check("align", align, exp_locked() && ecount == lock_edge);
    check("cen", cen, exp_cen());
  endtask
  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask
  task automatic wr(input int ch, input int num, input int den);
    cfg_we = 1'b1;
    cfg_ch = 3'(ch);
    cfg_num = 16'(num);
    cfg_den = 16'(den);
    step();
    cfg_we = 1'b0;
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    #1;
    check("rst_locked", locked, 1'b0);
    check("rst_align", align, 1'b0);
    check("rst_cen", cen, '0);
    run(3);
    rst_n = 1'b1;
    run(40);
    wr(1, 2, 5);
    run(40);
    wr(2, 7, 7);
    run(30);
    wr(3, 5, 3);
    wr(0, 1, 0);
    run(40);
    pulse_reset();
    run(13);
    wr(1, 3, 4);
    wr(6, 9, 9);
    run(40);
    begin
      int k = 0;
      while (k < 50 && !cen[0]) begin
        step();
        k++;
      end
      check("cen0_seen", cen[0], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_locked", locked, 1'b0);
      check("async_align", align, 1'b0);
      check("async_cen", cen, '0);
      step();
      rst_n = 1'b1;
      run(30);
    end
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0)
        wr($urandom_range(0, 7), $urandom_range(0, 11), $urandom_range(0, 10));
      else
        step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
